// File: rtl/mod_add_serial.sv
// Serial secp256k1 field adder: sum = (x + y) mod P, LIMB_W bits per cycle.
// Ports: clk, rst_n, in_valid/in_ready/x/y in, out_valid/out_ready/sum out.
module mod_add_serial #(
  parameter int          LIMB_W = 32,
  parameter logic [255:0] P     =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] x,
  input  logic [255:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] sum
);

  localparam int NLIMB = 256 / LIMB_W;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam int SH    = $clog2(LIMB_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic          carry;
  logic          borrow;
  logic [255:0]  xr;
  logic [255:0]  yr;
  logic [255:0]  sr;
  logic [255:0]  tr;
  logic [7:0]    base;
  logic [LIMB_W:0] s_i;
  logic [LIMB_W:0] t_i;
  logic          last;

  // Limb bit offset; LIMB_W is a power of two so a shift suffices.
  assign base = 8'(cnt) << SH;
  assign last = (cnt == CW'(NLIMB - 1));

  assign s_i = {1'b0, xr[base +: LIMB_W]}
             + {1'b0, yr[base +: LIMB_W]}
             + {{LIMB_W{1'b0}}, carry};

  // Trial subtraction of P runs one limb behind nothing: it
  // consumes the freshly formed sum limb in the same cycle.
  assign t_i = {1'b0, s_i[LIMB_W-1:0]}
             - {1'b0, P[base +: LIMB_W]}
             - {{LIMB_W{1'b0}}, borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      sr     <= '0;
      tr     <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        xr     <= x;
        yr     <= y;
        cnt    <= '0;
        carry  <= 1'b0;
        borrow <= 1'b0;
      end else if (state == RUN) begin
        sr[base +: LIMB_W] <= s_i[LIMB_W-1:0];
        tr[base +: LIMB_W] <= t_i[LIMB_W-1:0];
        carry  <= s_i[LIMB_W];
        borrow <= t_i[LIMB_W];
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // x+y >= P when the add overflowed 256 bits or the trial
  // subtraction did not underflow; then T is the reduced value.
  assign sum = out_valid ? ((carry | ~borrow) ? tr : sr) : '0;

endmodule

// File: tb/tb_mod_add_serial.sv
// Self-checking bench for mod_add_serial.
// Directed table, handshake corner cases and random ops vs a model.
module tb_mod_add_serial;

  localparam int LIMB_W = 32;
  localparam int NLIMB  = 256 / LIMB_W;
  localparam logic [255:0] P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] x;
  logic [255:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] sum;

  int errors = 0;
  int checks = 0;

  mod_add_serial #(.LIMB_W(LIMB_W), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] s;
  } vec_t;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd_fe();
    logic [255:0] r;
    r = rnd256();
    if (r >= P) r = r - P;
    return r;
  endfunction

  // Reference: integer sum, reduced once if it reaches P.
  function automatic logic [255:0] ref_add(logic [255:0] a, logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  task automatic chk256(input string nm, input logic [255:0] act,
                        input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [255:0] a, input logic [255:0] b,
                        input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chkint({nm, " in_ready"}, int'(in_ready), 1);
    x = a;
    y = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = rnd256();
    y = rnd256();
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      tick();
      n++;
    end
    chkint({nm, " latency"}, n, NLIMB);
  endtask

  task automatic do_op(input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] exp, input int stall,
                       input string nm);
    accept(a, b, nm);
    wait_out(nm);
    repeat (stall) tick();
    chk256({nm, " sum"}, sum, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkint({nm, " drop"}, int'(out_valid), 0);
  endtask

  vec_t tv[7];
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] hold;
  int k;

  initial begin
    tv[0] = '{256'd1, 256'd2, 256'd3};
    tv[1] = '{P - 256'd1, 256'd1, 256'd0};
    tv[2] = '{P - 256'd1, P - 256'd1, P - 256'd2};
    tv[3] = '{P - 256'd1, 256'd0, P - 256'd1};
    tv[4] = '{256'd1 << 255, 256'd1 << 255, 256'h1000003D1};
    tv[5] = '{256'd0, 256'd0, 256'd0};
    tv[6] = '{P - 256'd2, 256'd3, 256'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    repeat (3) tick();
    chkint("reset in_ready", int'(in_ready), 1);
    chkint("reset out_valid", int'(out_valid), 0);
    chk256("reset sum", sum, '0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      do_op(tv[i].a, tv[i].b, tv[i].s, 0, $sformatf("vec%0d", i));

    // Hold the result for 5 cycles while in_valid pulses.
    a = rnd_fe();
    b = rnd_fe();
    accept(a, b, "stall");
    wait_out("stall");
    hold = sum;
    chk256("stall sum", hold, ref_add(a, b));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      x = rnd256();
      tick();
      chkint("stall out_valid", int'(out_valid), 1);
      chkint("stall in_ready", int'(in_ready), 0);
      chk256("stall stable", sum, hold);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkint("stall drop", int'(out_valid), 0);
    do_op(256'd10, 256'd20, 256'd30, 0, "after_stall");

    // Abort mid-run with reset.
    accept(P - 256'd1, P - 256'd1, "abort");
    k = (NLIMB > 3) ? 3 : 0;
    repeat (k) tick();
    rst_n = 1'b0;
    #1;
    chkint("abort out_valid", int'(out_valid), 0);
    chkint("abort in_ready", int'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chkint("post_abort in_ready", int'(in_ready), 1);
    do_op(256'd5, 256'd7, 256'd12, 0, "post_abort");

    for (int i = 0; i < 1000; i++) begin
      a = rnd_fe();
      b = rnd_fe();
      if (i % 10 == 0) a = P - 256'd1 - 256'($urandom_range(3));
      do_op(a, b, ref_add(a, b), $urandom_range(3),
            $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
